// File: rtl/nnue_pkg.sv
// Shared constants for the streaming NNUE activation block.
package nnue_pkg;

    // Activation mode encodings (mode 3 is reserved and falls back to clipped ReLU)
    localparam logic [1:0] ACT_CLIP   = 2'd0;
    localparam logic [1:0] ACT_SQCLIP = 2'd1;
    localparam logic [1:0] ACT_SAT    = 2'd2;

    // Sequencer states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    // Default datapath widths
    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 8;
    localparam int DEF_SHIFT = 6;

endpackage

// File: rtl/nnue_act_lane.sv
// Single-element activation: arithmetic shift, then clamp according to mode.
// Purely combinational; the stream block instantiates one per lane.
module nnue_act_lane
    import nnue_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic [IN_W-1:0]  x,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] y,
    output logic             sat
);

    localparam logic signed [IN_W-1:0] QMAX = IN_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] QMIN = ~QMAX;

    logic signed [IN_W-1:0]  w_s;
    logic                    w_hi;
    logic                    w_lo;
    logic [OUT_W-1:0]        w_clip;
    logic [OUT_W-1:0]        w_ssat;
    logic [2*OUT_W-1:0]      w_sq;

    assign w_s  = $signed(x) >>> SHIFT;
    assign w_hi = (w_s > QMAX);
    assign w_lo = (w_s < QMIN);

    // Unsigned clip to [0, QMAX]; negatives go to zero without counting as saturation
    always_comb begin
        if (w_s[IN_W-1])
            w_clip = '0;
        else if (w_hi)
            w_clip = QMAX[OUT_W-1:0];
        else
            w_clip = w_s[OUT_W-1:0];
    end

    // Signed saturate to [QMIN, QMAX]
    always_comb begin
        if (w_hi)
            w_ssat = QMAX[OUT_W-1:0];
        else if (w_lo)
            w_ssat = QMIN[OUT_W-1:0];
        else
            w_ssat = w_s[OUT_W-1:0];
    end

    // Square of the clipped value, renormalised so QMAX^2 lands just below QMAX
    assign w_sq = {{OUT_W{1'b0}}, w_clip} * {{OUT_W{1'b0}}, w_clip};

    // Mode select for output value and saturation flag
    always_comb begin
        case (mode)
            ACT_SQCLIP: begin
                y   = OUT_W'(w_sq >> (OUT_W - 1));
                sat = w_hi;
            end
            ACT_SAT: begin
                y   = w_ssat;
                sat = w_hi | w_lo;
            end
            default: begin
                y   = w_clip;
                sat = w_hi;
            end
        endcase
    end

endmodule

// File: rtl/nnue_act_stream.sv
// Streaming scaled activation between NNUE linear layers.
// Accepts a whole vector, processes LANES elements per beat, then holds the
// result until the consumer takes it.
//
//   state | meaning
//   IDLE  | waiting for an input vector (in_ready high)
//   RUN   | one beat of LANES elements per cycle
//   HOLD  | result valid, waiting for out_ready
module nnue_act_stream
    import nnue_pkg::*;
#(
    parameter int N     = 16,
    parameter int LANES = 4,
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [0:N*IN_W-1]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:N*OUT_W-1]       out_data,
    output logic [$clog2(N+1)-1:0]   sat_count,
    output logic                     busy
);

    localparam int BEATS = N / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(N + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (N % LANES != 0) begin : g_bad_lanes
        $error("nnue_act_stream: N must be a multiple of LANES");
    end

    logic [1:0]            r_state;
    logic [0:N*IN_W-1]     r_buf;
    logic [1:0]            r_mode;
    logic [BW-1:0]         r_beat;
    logic [0:N*OUT_W-1]    r_out;
    logic [CW-1:0]         r_sat;

    logic [IN_W-1:0]       w_x [LANES];
    logic [OUT_W-1:0]      w_y [LANES];
    logic [LANES-1:0]      w_sat;
    logic [CW-1:0]         w_beat_sat;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_x[l] = r_buf[(int'(r_beat) * LANES + l) * IN_W +: IN_W];

        nnue_act_lane #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_lane (
            .x    (w_x[l]),
            .mode (r_mode),
            .y    (w_y[l]),
            .sat  (w_sat[l])
        );
    end

    // Number of lanes that saturated in the current beat
    always_comb begin
        w_beat_sat = '0;
        for (int l = 0; l < LANES; l++)
            w_beat_sat = w_beat_sat + CW'(w_sat[l]);
    end

    // Sequencer, input buffer, output register and saturation counter
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_mode  <= ACT_CLIP;
            r_beat  <= '0;
            r_out   <= '0;
            r_sat   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_buf   <= in_data;
                        r_mode  <= mode;
                        r_sat   <= '0;
                        r_beat  <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++)
                        r_out[(int'(r_beat) * LANES + l) * OUT_W +: OUT_W] <= w_y[l];
                    r_sat <= r_sat + w_beat_sat;
                    if (r_beat == LAST_BEAT)
                        r_state <= HOLD;
                    else
                        r_beat <= r_beat + BW'(1);
                end
                HOLD: begin
                    if (out_ready)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == RUN) || (r_state == HOLD);
    assign out_data  = r_out;
    assign sat_count = r_sat;

endmodule

// File: tb/tb_nnue_act_stream.sv
// Directed bench for nnue_act_stream with hand-computed expected vectors.
module tb_nnue_act_stream;

    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SHIFT = 6;
    localparam int CW    = $clog2(N + 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [0:N*IN_W-1]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [0:N*OUT_W-1]     out_data;
    logic [CW-1:0]          sat_count;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;

    logic [IN_W-1:0]  vin  [N];
    logic [OUT_W-1:0] vexp [N];

    always #5 clk = ~clk;

    nnue_act_stream #(
        .N     (N),
        .LANES (LANES),
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat_count (sat_count),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < N; i++) begin
            vin[i]  = '0;
            vexp[i] = '0;
        end
    endtask

    // Offer vin with mode m, switch mode to m_run after acceptance, wait for out_valid
    task automatic run_vec(input logic [1:0] m, input logic [1:0] m_run, input int exp_sat);
        int lat;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            in_data[i*IN_W +: IN_W] = vin[i];
        mode     = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode     = m_run;
        in_data  = '1;
        chk("busy_after_accept", 64'(busy), 64'(1));
        chk("in_ready_in_run", 64'(in_ready), 64'(0));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(N / LANES));
        for (int i = 0; i < N; i++)
            chk($sformatf("el%0d", i), 64'(out_data[i*OUT_W +: OUT_W]), 64'(vexp[i]));
        chk("sat_count", 64'(sat_count), 64'(exp_sat));
    endtask

    // Complete the output handshake and confirm return to IDLE
    task automatic take_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_take", 64'(out_valid), 64'(0));
        chk("in_ready_after_take", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [OUT_W-1:0] held_el0;
        logic [CW-1:0]    held_sat;

        rst_n     = 1'b1;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;

        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_data", 64'(out_data[0:63]) | 64'(out_data[64:127]), 64'(0));
        chk("rst_sat", 64'(sat_count), 64'(0));

        // Mode 0: clipped ReLU
        clear_vec();
        vin[0]  = 16'h1FC0; vexp[0]  = 8'd127;
        vin[1]  = 16'h2000; vexp[1]  = 8'd127;
        vin[2]  = 16'h8000; vexp[2]  = 8'd0;
        vin[3]  = 16'h0100; vexp[3]  = 8'd4;
        vin[13] = 16'h0040; vexp[13] = 8'd1;
        run_vec(2'd0, 2'd0, 1);
        take_out();

        // Mode 1: squared clipped ReLU
        clear_vec();
        vin[0] = 16'h1FC0; vexp[0] = 8'd126;
        vin[1] = 16'h0400; vexp[1] = 8'd2;
        vin[2] = 16'h2000; vexp[2] = 8'd126;
        vin[9] = 16'h0800; vexp[9] = 8'd8;
        run_vec(2'd1, 2'd1, 1);
        take_out();

        // Mode 2: signed saturate
        clear_vec();
        vin[0] = 16'hE000; vexp[0] = 8'h80;
        vin[1] = 16'hC000; vexp[1] = 8'h80;
        vin[2] = 16'h1FC0; vexp[2] = 8'h7F;
        vin[3] = 16'h2000; vexp[3] = 8'h7F;
        vin[5] = 16'hFFC0; vexp[5] = 8'hFF;
        run_vec(2'd2, 2'd2, 2);
        take_out();

        // Backpressure: output held, in_valid pulses ignored
        clear_vec();
        vin[0]  = 16'h0C80; vexp[0]  = 8'd50;
        vin[15] = 16'h7FFF; vexp[15] = 8'd127;
        run_vec(2'd0, 2'd0, 1);
        held_el0 = out_data[0:7];
        held_sat = sat_count;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mode     = 2'd2;
            in_data  = {N{16'hC000}};
            @(posedge clk);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_el0", 64'(out_data[0:7]), 64'(held_el0));
            chk("bp_sat", 64'(sat_count), 64'(held_sat));
        end
        in_valid = 1'b0;
        chk("bp_el15", 64'(out_data[120:127]), 64'(8'd127));
        take_out();

        // Mode change during RUN is ignored; results follow mode 0
        clear_vec();
        vin[4] = 16'hC000; vexp[4] = 8'd0;
        vin[6] = 16'h0200; vexp[6] = 8'd8;
        run_vec(2'd0, 2'd2, 0);
        take_out();

        // Reserved mode 3 behaves as clipped ReLU
        clear_vec();
        vin[0]  = 16'h8000; vexp[0]  = 8'd0;
        vin[11] = 16'h2000; vexp[11] = 8'd127;
        run_vec(2'd3, 2'd3, 1);
        take_out();

        // Reset mid-RUN at beat 2, then a fresh vector
        @(negedge clk);
        for (int i = 0; i < N; i++)
            in_data[i*IN_W +: IN_W] = 16'h2000;
        mode     = 2'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_sat", 64'(sat_count), 64'(0));
        @(negedge clk);
        rst_n = 1'b0;
        clear_vec();
        vin[0]  = 16'h0100; vexp[0]  = 8'd4;
        vin[14] = 16'h3000; vexp[14] = 8'd127;
        run_vec(2'd0, 2'd0, 1);
        take_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nnue_act_stream.md
Name: nnue_act_stream

Overview:
- Parametrised, sequential successor to the combinational scaled clipped-ReLU between the NNUE linear layers.
- Accepts one whole pre-activation vector through a valid/ready handshake, then processes LANES elements per cycle over N/LANES beats.
- Supports selectable activation modes and counts saturated elements; the quantised vector is presented through a valid/ready handshake.
- Sits between a Linear layer output and the next Linear layer input.

Parameters:
- N, 16, elements per vector; must be a multiple of LANES.
- LANES, 4, elements processed per cycle (activation units instantiated).
- IN_W, 16, signed two's-complement pre-activation width per element.
- OUT_W, 8, output element width.
- SHIFT, 6, arithmetic right-shift applied before clamping.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-high (port name kept per codebase convention; asserted = 1).
- mode  in  2  activation select, sampled at input acceptance: 0 clipped ReLU, 1 squared clipped ReLU, 2 signed saturate, 3 reserved (behaves as 0).
- in_valid  in  1  in_data/mode valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  N*IN_W  vector, MSB-first packing: element 0 at bits [0:IN_W-1] of a [0:N*IN_W-1] bus.
- out_valid  out  1  out_data/sat_count valid.
- out_ready  in  1  consumer accepts output.
- out_data  out  N*OUT_W  result vector, same MSB-first packing.
- sat_count  out  $clog2(N+1)  number of elements clamped at a saturation bound.
- busy  out  1  high in RUN or HOLD.

Behaviour:
- Reset (rst_n=1, async): state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, sat_count=0, beat counter=0, input buffer=0.
- FSM IDLE -> RUN -> HOLD -> IDLE.
  - IDLE: in_ready=1. When in_valid=1 at an edge, latch in_data and mode into the buffer, clear sat_count and the beat counter, and go to RUN.
  - RUN: in_ready=0. Each cycle processes elements beat*LANES .. beat*LANES+LANES-1 and writes them into the output register. sat_count increments by the number of saturated lanes in that beat. On the last beat (N/LANES-1), go to HOLD and set out_valid=1.
  - HOLD: out_valid=1. out_data and sat_count are held stable. When out_ready=1 at an edge, clear out_valid and go to IDLE.
- in_ready is 0 in HOLD even when out_ready=1, so the next vector is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid is high N/LANES edges after the acceptance edge (4 for defaults). Throughput is one vector per N/LANES+2 cycles.
- Per element, let s = x >>> SHIFT (arithmetic shift, IN_W-SHIFT bits, signed). QMAX = 2^(OUT_W-1)-1.
  - mode 0/3: s<0 -> 0 (not counted as saturation). s>QMAX -> QMAX (counted). Otherwise s[OUT_W-1:0].
  - mode 1: compute c as in mode 0 (same saturation count), then out = (c*c) >> (OUT_W-1). Use a 2*OUT_W-bit product; the result is at most QMAX-1.
  - mode 2: clamp s to [-2^(OUT_W-1), QMAX] and output two's complement. Clamping at either bound counts as saturation. Exact bound values do not count.
- in_valid or in_data changes during RUN/HOLD are ignored. The mode input is ignored except at acceptance.
- Reset mid-RUN or mid-HOLD discards the in-flight vector immediately. There is no partial output.
- Elaboration fails if N % LANES != 0.

Decomposition:
- Package nnue_pkg holds:
  - mode encodings: ACT_CLIP=0, ACT_SQCLIP=1, ACT_SAT=2;
  - FSM state constants IDLE/RUN/HOLD;
  - default widths IN_W=16, OUT_W=8, SHIFT=6.
- Sub-module nnue_act_lane: purely combinational single-element activation with inputs x and mode, outputs y and sat. It is instantiated LANES times in a generate loop, with lane muxing driven by the beat counter.

Test Plan:
- Reset mid-RUN, then a new vector: assert rst_n for 1 cycle at beat 2 -> out_valid=0, in_ready=1 immediately; the next vector produces only its own results, with sat_count counting only that vector.
- Mode 0, defaults: elements 0x1FC0, 0x2000, 0x8000, 0x0100 (others 0) -> outputs 127, 127, 0, 4, rest 0; sat_count=1; out_valid 4 edges after acceptance.
- Mode 1: 0x1FC0 -> 126; 0x0400 -> 2; 0x2000 -> 126 with sat_count=1.
- Mode 2: 0xE000 -> 0x80, no saturation; 0xC000 -> 0x80, saturated; 0x1FC0 -> 0x7F; 0x2000 -> 0x7F, saturated -> sat_count=2.
- Backpressure: hold out_ready=0 for 10 cycles -> out_data/sat_count stay stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 -> IDLE, and the next vector is accepted the following cycle.
- Mode change mid-RUN: accept with mode=0, drive mode=2 during RUN -> results follow mode 0. Mode 3 with 0x8000 -> 0.
